// File: rtl/regfile_mp.sv
// Multi-port integer register file with a per-register pending-write scoreboard.
// Reads are combinational; writes, issue marks and flushes take effect on the clock edge.
module regfile_mp #(
   parameter int XLEN    = 32,
   parameter int NREGS   = 32,
   parameter int NR      = 2,
   parameter int NW      = 1,
   parameter int ZERO_R0 = 1,
   parameter int BYPASS  = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NR*$clog2(NREGS)-1:0] rd_addr,
   output logic [NR*XLEN-1:0]          rd_data,
   output logic [NR-1:0]               rd_busy,
   input  logic [NW-1:0]               wr_en,
   input  logic [NW*$clog2(NREGS)-1:0] wr_addr,
   input  logic [NW*XLEN-1:0]          wr_data,
   input  logic                        iss_en,
   input  logic [$clog2(NREGS)-1:0]    iss_addr,
   input  logic                        flush
);

   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;
   logic [NREGS-1:0] wr_hit;
   logic [XLEN-1:0]  wr_val [NREGS];
   logic [NREGS-1:0] iss_hit;

   // Per-register write decode; the later (higher-index) port overrides earlier ones.
   always_comb begin
      for (int r = 0; r < NREGS; r++) begin
         wr_hit[r]  = 1'b0;
         wr_val[r]  = '0;
         iss_hit[r] = iss_en && (iss_addr == AW'(r));
         for (int w = 0; w < NW; w++) begin
            if (wr_en[w] && (wr_addr[w*AW +: AW] == AW'(r))) begin
               wr_hit[r] = 1'b1;
               wr_val[r] = wr_data[w*XLEN +: XLEN];
            end
         end
      end
      if (ZERO_R0 != 0) begin
         wr_hit[0]  = 1'b0;
         iss_hit[0] = 1'b0;
      end
   end

   // Scoreboard priority: flush, then issue, then writeback clear.
   always_comb begin
      busy_d = busy_q;
      for (int r = 0; r < NREGS; r++) begin
         if (flush) begin
            busy_d[r] = 1'b0;
         end else if (iss_hit[r]) begin
            busy_d[r] = 1'b1;
         end else if (wr_hit[r]) begin
            busy_d[r] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREGS; r++) begin
            regs_q[r] <= '0;
         end
         busy_q <= '0;
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            if (wr_hit[r]) begin
               regs_q[r] <= wr_val[r];
            end
         end
         busy_q <= busy_d;
      end
   end

   // Register 0 never receives a write when hardwired, so its flop is constant and trims away.
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int p = 0; p < NR; p++) begin
         rd_data[p*XLEN +: XLEN] = regs_q[rd_addr[p*AW +: AW]];
         rd_busy[p]              = busy_q[rd_addr[p*AW +: AW]];
         if ((BYPASS != 0) && wr_hit[rd_addr[p*AW +: AW]]) begin
            rd_data[p*XLEN +: XLEN] = wr_val[rd_addr[p*AW +: AW]];
            if (!iss_hit[rd_addr[p*AW +: AW]]) begin
               rd_busy[p] = 1'b0;
            end
         end
         if ((ZERO_R0 != 0) && (rd_addr[p*AW +: AW] == '0)) begin
            rd_data[p*XLEN +: XLEN] = '0;
            rd_busy[p]              = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized, self-checking bench for regfile_mp (3 read ports, 2 write ports, r0 hardwired, bypass on).
// A behavioural model of architectural state predicts every read port each cycle.
module tb_regfile_mp;

   localparam int XLEN    = 32;
   localparam int NREGS   = 32;
   localparam int AW      = 5;
   localparam int NR      = 3;
   localparam int NW      = 2;
   localparam int ZERO_R0 = 1;
   localparam int BYPASS  = 1;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NR*AW-1:0]     rd_addr;
   logic [NR*XLEN-1:0]   rd_data;
   logic [NR-1:0]        rd_busy;
   logic [NW-1:0]        wr_en;
   logic [NW*AW-1:0]     wr_addr;
   logic [NW*XLEN-1:0]   wr_data;
   logic                 iss_en;
   logic [AW-1:0]        iss_addr;
   logic                 flush;

   logic [XLEN-1:0]      mdl_regs [NREGS];
   logic                 mdl_busy [NREGS];
   int                   num_checks = 0;
   int                   num_errors = 0;

   regfile_mp #(
      .XLEN(XLEN), .NREGS(NREGS), .NR(NR), .NW(NW), .ZERO_R0(ZERO_R0), .BYPASS(BYPASS)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
      num_checks++;
      if (got !== exp) begin
         num_errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1, input logic [AW-1:0] ra2,
                                input logic [NW-1:0] we,
                                input logic [AW-1:0] wa0, input logic [XLEN-1:0] wd0,
                                input logic [AW-1:0] wa1, input logic [XLEN-1:0] wd1,
                                input logic ie, input logic [AW-1:0] ia, input logic fl);
      rd_addr  = {ra2, ra1, ra0};
      wr_en    = we;
      wr_addr  = {wa1, wa0};
      wr_data  = {wd1, wd0};
      iss_en   = ie;
      iss_addr = ia;
      flush    = fl;
   endtask

   task automatic readOnly(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
      applyStimulus(ra0, ra1, 5'd0, 2'b00, 5'd0, '0, 5'd0, '0, 1'b0, 5'd0, 1'b0);
   endtask

   function automatic logic [XLEN-1:0] portData(input int p);
      return rd_data[p*XLEN +: XLEN];
   endfunction

   function automatic logic [XLEN-1:0] portBusy(input int p);
      return {{(XLEN-1){1'b0}}, rd_busy[p]};
   endfunction

   function automatic logic dropped(input logic [AW-1:0] a);
      return (ZERO_R0 != 0) && (a == 0);
   endfunction

   // Read prediction: stored state, overridden by the last enabled writer when bypassing.
   function automatic logic [XLEN-1:0] expData(input int p);
      logic [AW-1:0]   a = rd_addr[p*AW +: AW];
      logic [XLEN-1:0] v;
      if (dropped(a)) return '0;
      v = mdl_regs[a];
      if (BYPASS != 0)
         for (int w = 0; w < NW; w++)
            if (wr_en[w] && wr_addr[w*AW +: AW] == a) v = wr_data[w*XLEN +: XLEN];
      return v;
   endfunction

   function automatic logic [XLEN-1:0] expBusy(input int p);
      logic [AW-1:0] a = rd_addr[p*AW +: AW];
      logic          written = 1'b0;
      if (dropped(a)) return '0;
      for (int w = 0; w < NW; w++)
         if (wr_en[w] && wr_addr[w*AW +: AW] == a) written = 1'b1;
      if (BYPASS != 0 && written && !(iss_en && iss_addr == a)) return '0;
      return {{(XLEN-1){1'b0}}, mdl_busy[a]};
   endfunction

   task automatic modelReset();
      for (int r = 0; r < NREGS; r++) begin
         mdl_regs[r] = '0;
         mdl_busy[r] = 1'b0;
      end
   endtask

   // Apply the cycle's effects in reverse priority so higher-priority rules land last.
   task automatic modelUpdate();
      logic [AW-1:0] a;
      if (!rst_n) return;
      for (int w = 0; w < NW; w++) begin
         a = wr_addr[w*AW +: AW];
         if (wr_en[w] && !dropped(a)) begin
            mdl_regs[a] = wr_data[w*XLEN +: XLEN];
            mdl_busy[a] = 1'b0;
         end
      end
      if (iss_en && !dropped(iss_addr)) mdl_busy[iss_addr] = 1'b1;
      if (flush) for (int r = 0; r < NREGS; r++) mdl_busy[r] = 1'b0;
   endtask

   task automatic settle();
      #1;
      for (int p = 0; p < NR; p++) begin
         checkOutput($sformatf("rd%0d_data", p), portData(p), expData(p));
         checkOutput($sformatf("rd%0d_busy", p), portBusy(p), expBusy(p));
      end
   endtask

   task automatic clockEdge();
      @(posedge clk);
      modelUpdate();
      @(negedge clk);
   endtask

   function automatic logic [AW-1:0] randAddr();
      if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
      return AW'($urandom_range(0, NREGS-1));
   endfunction

   initial begin
      rst_n = 1'b0;
      readOnly(5'd0, 5'd0);
      modelReset();
      #1;
      checkOutput("reset_data", portData(0), 32'h0);
      checkOutput("reset_busy", portBusy(0), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // T1: write+issue x5, then assert reset between edges.
      applyStimulus(5'd5, 5'd5, 5'd0, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, '0, 1'b1, 5'd5, 1'b0);
      settle();
      clockEdge();
      readOnly(5'd5, 5'd0);
      settle();
      checkOutput("t1_stored", portData(0), 32'hDEADBEEF);
      checkOutput("t1_busy_before_rst", portBusy(0), 32'h1);
      #3;
      rst_n = 1'b0;
      modelReset();
      #1;
      checkOutput("t1_rst_data", portData(0), 32'h0);
      checkOutput("t1_rst_busy", portBusy(0), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(5'd5, 5'd0, 5'd0, 2'b01, 5'd5, 32'h00000001, 5'd0, '0, 1'b0, 5'd0, 1'b0);
      settle();
      clockEdge();
      readOnly(5'd5, 5'd0);
      settle();
      checkOutput("t1_first_write", portData(0), 32'h1);

      // T2: r0 is hardwired even when written and issued.
      applyStimulus(5'd0, 5'd0, 5'd0, 2'b01, 5'd0, 32'h1234, 5'd0, '0, 1'b1, 5'd0, 1'b0);
      settle();
      checkOutput("t2_r0_data", portData(0), 32'h0);
      checkOutput("t2_r0_busy", portBusy(0), 32'h0);
      clockEdge();
      readOnly(5'd0, 5'd0);
      settle();
      checkOutput("t2_r0_data_next", portData(0), 32'h0);
      checkOutput("t2_r0_busy_next", portBusy(0), 32'h0);

      // T3: same-cycle bypass of a new value over an old one.
      applyStimulus(5'd7, 5'd0, 5'd0, 2'b01, 5'd7, 32'h11111111, 5'd0, '0, 1'b0, 5'd0, 1'b0);
      settle();
      clockEdge();
      applyStimulus(5'd7, 5'd7, 5'd0, 2'b01, 5'd7, 32'hA5A5A5A5, 5'd0, '0, 1'b0, 5'd0, 1'b0);
      settle();
      checkOutput("t3_bypass", portData(1), 32'hA5A5A5A5);
      clockEdge();
      readOnly(5'd7, 5'd0);
      settle();
      checkOutput("t3_stored", portData(0), 32'hA5A5A5A5);

      // T4: both write ports target x3; port 1 wins.
      applyStimulus(5'd3, 5'd3, 5'd3, 2'b11, 5'd3, 32'h11, 5'd3, 32'h22, 1'b0, 5'd0, 1'b0);
      settle();
      checkOutput("t4_bypass", portData(2), 32'h22);
      clockEdge();
      readOnly(5'd3, 5'd0);
      settle();
      checkOutput("t4_stored", portData(0), 32'h22);

      // T5: scoreboard set, re-issue on writeback, clear, flush.
      applyStimulus(5'd9, 5'd0, 5'd0, 2'b00, 5'd0, '0, 5'd0, '0, 1'b1, 5'd9, 1'b0);
      settle();
      checkOutput("t5_iss_same_cycle", portBusy(0), 32'h0);
      clockEdge();
      applyStimulus(5'd9, 5'd0, 5'd0, 2'b01, 5'd9, 32'h99, 5'd0, '0, 1'b1, 5'd9, 1'b0);
      settle();
      checkOutput("t5_busy_after_iss", portBusy(0), 32'h1);
      clockEdge();
      applyStimulus(5'd9, 5'd0, 5'd0, 2'b01, 5'd9, 32'h98, 5'd0, '0, 1'b0, 5'd0, 1'b0);
      settle();
      checkOutput("t5_busy_reissued", portBusy(0), 32'h0);
      clockEdge();
      readOnly(5'd9, 5'd0);
      settle();
      checkOutput("t5_busy_cleared", portBusy(0), 32'h0);
      applyStimulus(5'd9, 5'd0, 5'd0, 2'b00, 5'd0, '0, 5'd0, '0, 1'b1, 5'd9, 1'b0);
      settle();
      clockEdge();
      applyStimulus(5'd9, 5'd4, 5'd0, 2'b00, 5'd0, '0, 5'd0, '0, 1'b1, 5'd4, 1'b1);
      settle();
      checkOutput("t5_busy_pre_flush", portBusy(0), 32'h1);
      clockEdge();
      readOnly(5'd9, 5'd4);
      settle();
      checkOutput("t5_flush_x9", portBusy(0), 32'h0);
      checkOutput("t5_flush_x4", portBusy(1), 32'h0);

      // T6: random traffic on all ports against the model.
      for (int c = 0; c < 10000; c++) begin
         applyStimulus(randAddr(), randAddr(), randAddr(),
                       NW'($urandom_range(0, 3)),
                       randAddr(), $urandom(), randAddr(), $urandom(),
                       ($urandom_range(0, 2) == 0), randAddr(),
                       ($urandom_range(0, 19) == 0));
         settle();
         clockEdge();
      end

      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

endmodule
